// File: rtl/pwm_meter.sv
// PWM receiver: synchronizes an asynchronous pulse input and reports the high time
// and rise-to-rise period of each completed cycle, with a sticky timeout for a dead input.
module pwm_meter #(
   parameter int Nbits = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             pwm_in,
   output logic [Nbits-1:0] width_out,
   output logic [Nbits-1:0] period_out,
   output logic             valid,
   output logic             timeout
);

   localparam logic [Nbits-1:0] CNT_MAX = '1;
   localparam logic [Nbits-1:0] CNT_ONE = Nbits'(1);

   typedef enum logic {IDLE, MEAS} state_t;

   state_t           state;
   logic             sync1, s, p;
   logic             rise;
   logic [Nbits-1:0] per_cnt, hi_cnt;

   assign rise = s & ~p;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         sync1      <= 1'b0;
         s          <= 1'b0;
         p          <= 1'b0;
         per_cnt    <= '0;
         hi_cnt     <= '0;
         width_out  <= '0;
         period_out <= '0;
         valid      <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         sync1 <= pwm_in;
         s     <= sync1;
         p     <= s;
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (enable && rise) begin
                  per_cnt <= CNT_ONE;
                  hi_cnt  <= CNT_ONE;
                  state   <= MEAS;
               end
            end
            MEAS: begin
               if (!enable) begin
                  state <= IDLE;
               end else if (rise) begin
                  // The rise cycle closes the old period and is cycle 1 of the next.
                  width_out  <= hi_cnt;
                  period_out <= per_cnt;
                  valid      <= 1'b1;
                  timeout    <= 1'b0;
                  per_cnt    <= CNT_ONE;
                  hi_cnt     <= CNT_ONE;
               end else if (per_cnt == CNT_MAX) begin
                  timeout <= 1'b1;
                  state   <= IDLE;
               end else begin
                  per_cnt <= per_cnt + CNT_ONE;
                  if (s) hi_cnt <= hi_cnt + CNT_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_meter.sv
// Randomized scoreboard bench for pwm_meter: the stimulus side predicts each
// measurement from the generated waveform; a monitor pops and compares on valid.
module tb_pwm_meter;

   localparam int NB   = 8;
   localparam int MAXC = (1 << NB) - 1;
   localparam int LAT  = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          enable = 1'b0;
   logic          pwm_in = 1'b0;
   logic [NB-1:0] width_out, period_out;
   logic          valid, timeout;

   pwm_meter #(.Nbits(NB)) dut (
      .clk(clk), .rst(rst), .enable(enable), .pwm_in(pwm_in),
      .width_out(width_out), .period_out(period_out),
      .valid(valid), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {int w; int p;} meas_t;
   meas_t q[$];
   meas_t mon_m;

   int vecs = 0, errs = 0;
   bit armed = 0, exp_to = 0;
   int prev_h = 0, prev_len = 0, last_w = 0, last_p = 0;

   task automatic chk(input string name, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every valid must match the oldest predicted measurement.
   always @(negedge clk) begin
      if (rst && valid) begin
         if (q.size() == 0) chk("spurious_valid", 1, 0);
         else begin
            mon_m = q.pop_front();
            chk("width", int'(width_out), mon_m.w);
            chk("period", int'(period_out), mon_m.p);
            chk("timeout_on_valid", int'(timeout), 0);
         end
      end
   end

   // Reference model: a rise ends the previous period if we were measuring it.
   task automatic model_rise();
      if (armed) begin
         if (prev_len <= MAXC) begin
            q.push_back('{w: prev_h, p: prev_len});
            last_w = prev_h;
            last_p = prev_len;
            exp_to = 0;
         end else exp_to = 1;
      end
      armed = enable;
   endtask

   task automatic drive_period(input int h, input int l, input int dis_at);
      pwm_in = 1'b1;
      model_rise();
      prev_h = h;
      prev_len = h + l;
      for (int i = 1; i <= h + l; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (i == LAT) chk("timeout_level", int'(timeout), int'(exp_to));
         if (i == h) pwm_in = 1'b0;
         if (dis_at > 0 && i == dis_at) begin
            enable = 1'b0;
            armed = 0;
         end
         if (dis_at > 0 && i == dis_at + 4) enable = 1'b1;
      end
   endtask

   task automatic stuck_high();
      int n;
      pwm_in = 1'b1;
      model_rise();
      n = 0;
      while (!timeout && n < 400) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk("timeout_latency", n, LAT + MAXC);
      chk("width_hold", int'(width_out), last_w);
      chk("period_hold", int'(period_out), last_p);
      armed = 0;
      exp_to = 1;
      repeat (5) @(negedge clk);
      pwm_in = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_width"}, int'(width_out), 0);
      chk({tag, "_period"}, int'(period_out), 0);
      chk({tag, "_valid"}, int'(valid), 0);
      chk({tag, "_timeout"}, int'(timeout), 0);
   endtask

   initial begin
      int h, l, d;
      // Reset with the input toggling.
      repeat (8) begin
         @(negedge clk);
         pwm_in = ~pwm_in;
      end
      check_zero("reset");
      pwm_in = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      enable = 1'b1;
      repeat (3) @(negedge clk);

      repeat (5) drive_period(3, 7, 0);
      repeat (3) drive_period(6, 4, 0);

      stuck_high();
      repeat (3) drive_period(3, 7, 0);

      // Boundary: 255 is a legal period, 256 times out.
      drive_period(100, 155, 0);
      drive_period(3, 7, 0);
      drive_period(100, 156, 0);
      repeat (3) drive_period(3, 7, 0);

      // Abort via enable, then asynchronous reset mid-measurement.
      drive_period(3, 20, 6);
      repeat (3) drive_period(3, 7, 0);
      rst = 1'b0;
      #1;
      check_zero("midreset");
      q.delete();
      armed = 0;
      exp_to = 0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) drive_period(3, 7, 0);

      for (int k = 0; k < 60; k++) begin
         h = $urandom_range(1, 30);
         l = $urandom_range(2, 30);
         if ($urandom_range(0, 9) == 0) l = 250 - h + $urandom_range(0, 10);
         d = 0;
         if (h + l >= 12 && $urandom_range(0, 7) == 0) d = $urandom_range(4, h + l - 5);
         drive_period(h, l, d);
      end
      pwm_in = 1'b0;
      repeat (20) @(negedge clk);
      chk("queue_drain", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
